// File: rtl/spi_regctrl_pkg.sv
// Shared types and sizes for the SPI register controller.
package spi_regctrl_pkg;

    localparam int NREGS = 16;
    localparam int ADDRW = 4;
    localparam int DATAW = 8;

    // SPI transaction tracker states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

endpackage

// File: rtl/spi_regctrl_spisync.sv
// Multi-flop synchronizer with rise/fall detection for one async level.
module spisync #(
    parameter int SYNCSTAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNCSTAGES-1:0] sync_q;
    logic                  prev_q;

    // Shift the async level through the chain; prev_q holds the last synced value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNCSTAGES-2:0], async_i};
            prev_q <= sync_q[SYNCSTAGES-1];
        end
    end

    assign level_o = sync_q[SYNCSTAGES-1];
    assign rise_o  = sync_q[SYNCSTAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNCSTAGES-1] & prev_q;

endmodule

// File: rtl/spi_regctrl.sv
// System-clock register bank behind the SPI slave, with a local host port.
// Handshake: hostrd/hostwr are levels held until hostack; hostack is a
// one-cycle pulse and a request is not sampled while hostack is high.
module spi_regctrl
    import spi_regctrl_pkg::*;
#(
    parameter int SYNCSTAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         spien,
    input  logic         rdt,
    input  logic         wrt,
    input  logic [3:0]   spiaddr,
    input  logic [7:0]   spiwrtdata,
    output logic [7:0]   spirddata,
    input  logic [3:0]   hostaddr,
    input  logic [7:0]   hostwrdata,
    input  logic         hostwr,
    input  logic         hostrd,
    output logic [7:0]   hostrddata,
    output logic         hostack,
    output logic [127:0] regout,
    output logic         regwrstb,
    output logic [3:0]   regwraddr,
    output logic         busy,
    output logic         spiabort,
    output logic [2:0]   dbg_state
);

    logic sen, sen_rise, sen_fall;
    logic srd, srd_rise, srd_fall;
    logic swr, swr_rise, swr_fall;
    logic sync_unused;

    spisync #(.SYNCSTAGES(SYNCSTAGES)) u_sync_en (
        .clk(clk), .resetn(resetn), .async_i(spien),
        .level_o(sen), .rise_o(sen_rise), .fall_o(sen_fall)
    );
    spisync #(.SYNCSTAGES(SYNCSTAGES)) u_sync_rd (
        .clk(clk), .resetn(resetn), .async_i(rdt),
        .level_o(srd), .rise_o(srd_rise), .fall_o(srd_fall)
    );
    spisync #(.SYNCSTAGES(SYNCSTAGES)) u_sync_wr (
        .clk(clk), .resetn(resetn), .async_i(wrt),
        .level_o(swr), .rise_o(swr_rise), .fall_o(swr_fall)
    );

    // Only some synchronizer outputs drive the FSM; the rest are intentionally idle.
    assign sync_unused = ^{sen_rise, sen_fall, srd, srd_fall, swr};

    state_e state_q, state_d;
    logic   spi_load_d;
    logic   abort_d;

    logic [DATAW-1:0] bank_q [NREGS];
    logic [DATAW-1:0] spirddata_q, hostrddata_q;
    logic             hostack_q, regwrstb_q, spiabort_q;
    logic [ADDRW-1:0] regwraddr_q;

    logic             host_go, host_wr_go;
    logic             bank_we;
    logic [ADDRW-1:0] bank_wa;
    logic [DATAW-1:0] bank_wd;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic, read-data load request and abort detection
    always_comb begin
        state_d    = state_q;
        spi_load_d = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sen) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (!sen) begin
                    state_d = ST_IDLE;
                end else if (srd_rise) begin
                    state_d    = ST_READ;
                    spi_load_d = 1'b1;
                end else if (swr_rise) begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (!sen) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                // A falling wrt with select still high means the slave counter wrapped.
                if (swr_fall && sen) begin
                    state_d = ST_COMMIT;
                end else if (!sen) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Host request acceptance; a host write defers for one cycle behind COMMIT
    assign host_go    = (hostrd | hostwr) & ~hostack_q & ~(hostwr & (state_q == ST_COMMIT));
    assign host_wr_go = host_go & hostwr;

    // Bank write port arbitration: SPI commit beats host write
    always_comb begin
        bank_we = 1'b0;
        bank_wa = '0;
        bank_wd = '0;
        if (state_q == ST_COMMIT) begin
            bank_we = 1'b1;
            bank_wa = spiaddr;
            bank_wd = spiwrtdata;
        end else if (host_wr_go) begin
            bank_we = 1'b1;
            bank_wa = hostaddr;
            bank_wd = hostwrdata;
        end
    end

    // Register bank storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < NREGS; n++) bank_q[n] <= '0;
        end else if (bank_we) begin
            bank_q[bank_wa] <= bank_wd;
        end
    end

    // Registered side outputs: read data, acks and strobes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spirddata_q  <= '0;
            hostrddata_q <= '0;
            hostack_q    <= 1'b0;
            regwrstb_q   <= 1'b0;
            regwraddr_q  <= '0;
            spiabort_q   <= 1'b0;
        end else begin
            if (spi_load_d) spirddata_q <= bank_q[spiaddr];
            // Reads the pre-write value when read and write share an ack
            if (host_go) hostrddata_q <= bank_q[hostaddr];
            hostack_q  <= host_go;
            regwrstb_q <= bank_we;
            if (bank_we) regwraddr_q <= bank_wa;
            spiabort_q <= abort_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regout
        assign regout[g*DATAW +: DATAW] = bank_q[g];
    end

    assign spirddata  = spirddata_q;
    assign hostrddata = hostrddata_q;
    assign hostack    = hostack_q;
    assign regwrstb   = regwrstb_q;
    assign regwraddr  = regwraddr_q;
    assign spiabort   = spiabort_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_regctrl.sv
// Directed bench for spi_regctrl: SPI write/read/abort, host access, collision.
module tb_spi_regctrl;
  import spi_regctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         spien = 0, rdt = 0, wrt = 0;
  logic [3:0]   spiaddr = 0;
  logic [7:0]   spiwrtdata = 0;
  logic [7:0]   spirddata;
  logic [3:0]   hostaddr = 0;
  logic [7:0]   hostwrdata = 0;
  logic         hostwr = 0, hostrd = 0;
  logic [7:0]   hostrddata;
  logic         hostack;
  logic [127:0] regout;
  logic         regwrstb;
  logic [3:0]   regwraddr;
  logic         busy;
  logic         spiabort;
  logic [2:0]   dbg_state;

  spi_regctrl #(.SYNCSTAGES(2)) dut (
    .clk(clk), .resetn(resetn),
    .spien(spien), .rdt(rdt), .wrt(wrt),
    .spiaddr(spiaddr), .spiwrtdata(spiwrtdata), .spirddata(spirddata),
    .hostaddr(hostaddr), .hostwrdata(hostwrdata),
    .hostwr(hostwr), .hostrd(hostrd),
    .hostrddata(hostrddata), .hostack(hostack),
    .regout(regout), .regwrstb(regwrstb), .regwraddr(regwraddr),
    .busy(busy), .spiabort(spiabort), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // strobe monitor, sampled on the falling edge
  int strb_cnt  = 0;
  int abort_cnt = 0;
  logic [3:0] last_wraddr = 0;
  always @(negedge clk) begin
    if (regwrstb) begin
      strb_cnt++;
      last_wraddr = regwraddr;
    end
    if (spiabort) abort_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic host_access(input logic [3:0] a, input logic [7:0] d,
                             input logic do_wr, input logic do_rd,
                             output int lat, output logic [7:0] rd);
    hostaddr = a; hostwrdata = d; hostwr = do_wr; hostrd = do_rd;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!hostack && lat < 6);
    if (!hostack) check("hostack_timeout", 0, 1);
    rd = hostrddata;
    hostwr = 0; hostrd = 0;
  endtask

  function automatic logic [7:0] reg_of(input logic [127:0] r, input int n);
    return r[n*8 +: 8];
  endfunction

  int         lat;
  logic [7:0] rd;
  int         base_s, base_a;
  int         k;

  initial begin : main
    // ---- reset state ----
    tick(3);
    check("rst_regout", regout, '0);
    check("rst_spirddata", spirddata, 8'h00);
    check("rst_hostrddata", hostrddata, 8'h00);
    check("rst_hostack", hostack, 1'b0);
    check("rst_regwrstb", regwrstb, 1'b0);
    check("rst_spiabort", spiabort, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    resetn = 1;
    tick(2);

    // ---- host write latency ----
    host_access(4'd1, 8'h77, 1, 0, lat, rd);
    check("hwr_latency", lat, 1);
    check("hwr_reg1", reg_of(regout, 1), 8'h77);

    // ---- reset mid-WRITE ----
    spiaddr = 4'd3; spiwrtdata = 8'hC3; spien = 1;
    tick(4);
    check("busy_in_xfer", busy, 1'b1);
    wrt = 1;
    tick(4);
    check("mid_write_state", dbg_state, ST_WRITE);
    base_s = strb_cnt;
    resetn = 0;
    #1;
    check("rstw_regout", regout, '0);
    check("rstw_state", dbg_state, ST_IDLE);
    check("rstw_regwrstb", regwrstb, 1'b0);
    spien = 0; wrt = 0;
    tick(3);
    check("rstw_no_strobe", strb_cnt - base_s, 0);
    resetn = 1;
    tick(2);

    // ---- full SPI write of 0xA5 to addr 3 ----
    base_s = strb_cnt; base_a = abort_cnt;
    spiaddr = 4'd3; spiwrtdata = 8'hA5; spien = 1;
    tick(3);
    wrt = 1;
    tick(8);
    wrt = 0;
    tick(3);
    check("spiw_not_yet", reg_of(regout, 3), 8'h00);
    tick(1);
    check("spiw_reg3", reg_of(regout, 3), 8'hA5);
    tick(2);
    spien = 0;
    tick(4);
    check("spiw_strobes", strb_cnt - base_s, 1);
    check("spiw_wraddr", last_wraddr, 4'd3);
    check("spiw_no_abort", abort_cnt - base_a, 0);
    check("spiw_idle", dbg_state, ST_IDLE);

    // ---- SPI read of addr 7 (0x3C), host read of addr 5 during it ----
    host_access(4'd7, 8'h3C, 1, 0, lat, rd);
    host_access(4'd5, 8'h5A, 1, 0, lat, rd);
    spiaddr = 4'd7; spien = 1;
    tick(3);
    rdt = 1;
    tick(2);
    check("spird_before_load", spirddata, 8'h00);
    tick(1);
    check("spird_loaded", spirddata, 8'h3C);
    check("spird_state", dbg_state, ST_READ);
    host_access(4'd5, 8'h00, 0, 1, lat, rd);
    check("hrd_during_read_lat", lat, 1);
    check("hrd_during_read_data", rd, 8'h5A);
    host_access(4'd7, 8'h99, 1, 0, lat, rd);
    tick(3);
    check("spird_stable", spirddata, 8'h3C);
    check("host_wr_addr7", reg_of(regout, 7), 8'h99);
    spien = 0; rdt = 0;
    tick(4);
    check("spird_idle", dbg_state, ST_IDLE);

    // ---- combined host read + write returns pre-write value ----
    base_s = strb_cnt;
    host_access(4'd5, 8'h66, 1, 1, lat, rd);
    check("hrw_lat", lat, 1);
    check("hrw_prewrite", rd, 8'h5A);
    check("hrw_reg5", reg_of(regout, 5), 8'h66);
    tick(1);
    check("hrw_one_strobe", strb_cnt - base_s, 1);

    // ---- aborted SPI write (SS dropped early) ----
    base_s = strb_cnt; base_a = abort_cnt;
    spiaddr = 4'd4; spiwrtdata = 8'hEE; spien = 1;
    tick(3);
    wrt = 1;
    tick(12);
    spien = 0;
    tick(4);
    wrt = 0;
    tick(3);
    check("abort_pulse", abort_cnt - base_a, 1);
    check("abort_no_strobe", strb_cnt - base_s, 0);
    check("abort_reg4", reg_of(regout, 4), 8'h00);
    check("abort_idle", dbg_state, ST_IDLE);

    // ---- host write colliding with SPI COMMIT on addr 2 ----
    spiaddr = 4'd2; spiwrtdata = 8'h22; spien = 1;
    tick(3);
    wrt = 1;
    tick(8);
    wrt = 0;
    base_s = strb_cnt;
    k = 0;
    while (dbg_state != ST_COMMIT && k < 10) begin
      tick(1);
      k++;
    end
    check("col_reach_commit", dbg_state, ST_COMMIT);
    hostaddr = 4'd2; hostwrdata = 8'h11; hostwr = 1;
    tick(1);
    check("col_spi_first", reg_of(regout, 2), 8'h22);
    check("col_no_ack_yet", hostack, 1'b0);
    check("col_spi_strobe_addr", regwraddr, 4'd2);
    tick(1);
    check("col_host_ack", hostack, 1'b1);
    check("col_final", reg_of(regout, 2), 8'h11);
    check("col_host_strobe", regwrstb, 1'b1);
    hostwr = 0;
    tick(4);
    spien = 0;
    tick(4);
    check("col_two_strobes", strb_cnt - base_s, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_regctrl.md
# spi_regctrl

System-clock register controller behind the 16-bit SPI slave. Brings the slave's SPI-clock-domain strobes (`spien`, `rdt`, `wrt`) into the `clk` domain and owns a 16 x 8 register bank. Supplies `rddata` for SPI reads and commits completed SPI writes. Arbitrates bank writes between SPI and a local host port; SPI has priority.

## Interface
- `SYNCSTAGES`, default 2: synchronizer depth for `spien`, `rdt`, `wrt` (minimum 2).
- `clk` in 1: system clock. Must satisfy f(clk) ≥ 4·f(spiclk).
- `resetn` in 1: asynchronous, active-low reset.
- `spien` in 1: SPI select, level from the slave side (async).
- `rdt` in 1: slave read-transaction strobe (async).
- `wrt` in 1: slave write-transaction strobe (async).
- `spiaddr` in 4: slave parallel address. Quasi-static once `rdt`/`wrt` is asserted.
- `spiwrtdata` in 8: slave parallel write data. Quasi-static after the 16th SPI clock.
- `spirddata` out 8: read data to slave `rddata`. Held stable between loads.
- `hostaddr` in 4: host register address.
- `hostwrdata` in 8: host write data.
- `hostwr` in 1: host write request. Level; held until `hostack`.
- `hostrd` in 1: host read request. Level; held until `hostack`.
- `hostrddata` out 8: host read data, valid with `hostack`.
- `hostack` out 1: one-cycle acknowledge.
- `regout` out 128: register bank, flattened; reg n is at [8n+7:8n].
- `regwrstb` out 1: one-cycle pulse on any bank write.
- `regwraddr` out 4: address of the write flagged by `regwrstb`.
- `busy` out 1: high while an SPI transaction is in progress (state ≠ IDLE).
- `spiabort` out 1: one-cycle pulse when an SPI write is dropped.

## Operation
- Synchronized copies are `sen`, `srd`, `swr`, each taken from `SYNCSTAGES` flops. Edge detect uses one more flop per signal.
- FSM states: IDLE, ADDR, READ, WRITE, COMMIT.
  - IDLE → ADDR when `sen` = 1.
  - ADDR → READ on a `srd` rising edge. On entry, `spirddata` ← bank[`spiaddr`].
  - ADDR → WRITE on a `swr` rising edge.
  - ADDR → IDLE when `sen` = 0.
  - READ → IDLE when `sen` = 0. `spirddata` is not reloaded while in READ.
  - WRITE → COMMIT on a `swr` falling edge while `sen` = 1 in the same cycle. This means the full 16 bits were clocked, because the slave counter wrapped.
  - WRITE → IDLE when `sen` = 0 without that qualifying edge. Pulse `spiabort`; the bank is unchanged.
  - COMMIT → IDLE after one cycle. In COMMIT: bank[`spiaddr`] ← `spiwrtdata`, `regwrstb` = 1, `regwraddr` = `spiaddr`.
- `sen` falling in any state other than COMMIT returns the FSM to IDLE.
- Host read: when `hostrd` = 1 and `hostack` = 0, the next cycle gives `hostack` = 1 and `hostrddata` = bank[`hostaddr`]. Host reads are never blocked.
- Host write: when `hostwr` = 1 and `hostack` = 0 and the FSM is not in COMMIT, the bank is written, with `regwrstb` and `hostack` on the next edge. If the FSM is in COMMIT, the host write waits one cycle; the SPI write wins.
- `hostrd` and `hostwr` together: the write is performed and the ack covers both. `hostrddata` returns the pre-write value.
- A host write to the same address as a pending SPI read does not change `spirddata` once it is loaded.

## Timing
- Reset: all bank registers 0x00, `spirddata` 0x00, `hostrddata` 0x00, all strobes 0, FSM in IDLE, synchronizers cleared.
- Read path: `srd` rises `SYNCSTAGES`+1 clk after `rdt`. `spirddata` is valid 1 clk later. Total ≤ `SYNCSTAGES`+2 clk, which is less than the 3 SPI periods before the slave's load at count 8.
- Write path: the bank is updated `SYNCSTAGES`+2 clk after `wrt` falls. The master must hold SS ≥ `SYNCSTAGES`+2 clk after the last SCLK edge; otherwise the write is aborted.
- Host access latency: 1 clk, or 2 clk when colliding with COMMIT.
- `busy` is registered and asserts 1 clk after `sen`.

## Structure
- Shared package `spi_regctrl_pkg`: FSM state enum, `NREGS`=16, `ADDRW`=4, `DATAW`=8.
- Sub-module `spisync`: parameterized `SYNCSTAGES` flop chain with async active-low reset plus edge detect. Outputs are the level and the rise/fall pulses. Instantiate it three times.
- Bank, FSM and host arbitration stay in the top level.

## Test plan
- Reset mid-WRITE: assert `resetn` = 0 → all `regout` = 0, FSM in IDLE, no `regwrstb`.
- SPI write of 0xA5 to addr 3 with SS held 6 clk after the last edge → `regout`[31:24] = 0xA5 and a single `regwrstb` with `regwraddr` = 3.
- SPI read of addr 7 preloaded with 0x3C → `spirddata` = 0x3C within 4 clk of `rdt` rising, stable until `spien` falls.
- SPI write with SS dropped after 12 SCLKs → `spiabort` pulse, bank unchanged, FSM returns to IDLE.
- Host write of 0x11 to addr 2 issued in the same cycle the SPI commits 0x22 to addr 2 → SPI write occurs first, host `hostack` arrives 1 clk later, final value 0x11, two `regwrstb` pulses.
- Host read of addr 5 holding 0x5A → `hostack` with `hostrddata` = 0x5A one clk later, including during an active SPI read.
